// File: rtl/simmem_wresp_delay_tracker.sv
// Holds (local_id, delay) pairs for their requested latency, then releases expired IDs one per cycle.
// Optional occupancy statistics ports are enabled by defining SIMMEM_WRESP_DELAY_TRACKER_STATS_EN.
module simmem_wresp_delay_tracker #(
    parameter int NumSlots   = 16,
    parameter int IdWidth    = 4,
    parameter int DelayWidth = 6
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [IdWidth-1:0]        local_id_i,
    input  logic [DelayWidth-1:0]     delay_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    output logic [IdWidth-1:0]        release_id_o,
    output logic                      release_valid_o,
    input  logic                      release_ready_i
`ifdef SIMMEM_WRESP_DELAY_TRACKER_STATS_EN
    ,
    output logic [$clog2(NumSlots):0] occupancy_o,
    output logic [$clog2(NumSlots):0] max_occupancy_o
`endif
);

    localparam int IdxWidth = $clog2(NumSlots);

    logic [NumSlots-1:0]   occ_q, occ_d;
    logic [IdWidth-1:0]    id_q  [NumSlots];
    logic [IdWidth-1:0]    id_d  [NumSlots];
    logic [DelayWidth-1:0] cnt_q [NumSlots];
    logic [DelayWidth-1:0] cnt_d [NumSlots];

    logic [NumSlots-1:0]   expired;
    logic [IdxWidth-1:0]   free_idx;
    logic [IdxWidth-1:0]   rel_idx;
    logic                  accept;
    logic                  release_fire;

    // Scanning from the top down leaves the lowest matching index in each encoder.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        expired  = '0;
        free_idx = '0;
        rel_idx  = '0;
        for (int i = NumSlots - 1; i >= 0; i--) begin
            expired[i] = occ_q[i] && (cnt_q[i] == '0);
            if (!occ_q[i]) free_idx = IdxWidth'(i);
            if (occ_q[i] && (cnt_q[i] == '0)) rel_idx = IdxWidth'(i);
        end
    end

    // Ready looks at registered occupancy only, so a slot freed this cycle is reusable next cycle.
    assign in_ready_o      = ~&occ_q;
    assign release_valid_o = |expired;
    assign release_id_o    = release_valid_o ? id_q[rel_idx] : '0;
    assign accept          = in_valid_i && in_ready_o;
    assign release_fire    = release_valid_o && release_ready_i;

    always_comb begin
        occ_d = occ_q;
        id_d  = id_q;
        cnt_d = cnt_q;
        for (int i = 0; i < NumSlots; i++) begin
            if (occ_q[i] && (cnt_q[i] != '0)) cnt_d[i] = cnt_q[i] - 1'b1;
        end
        if (release_fire) occ_d[rel_idx] = 1'b0;
        // Accept only targets a slot free at cycle start, never the one being released.
        if (accept) begin
            occ_d[free_idx] = 1'b1;
            id_d[free_idx]  = local_id_i;
            cnt_d[free_idx] = delay_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            occ_q <= '0;
            // NOTE: the slot array is small flop storage, so clearing it fully on reset is cheap and
            // keeps release_id_o deterministic; a RAM-backed store would reset only the occupied bits.
            for (int i = 0; i < NumSlots; i++) begin
                id_q[i]  <= '0;
                cnt_q[i] <= '0;
            end
        end else begin
            occ_q <= occ_d;
            id_q  <= id_d;
            cnt_q <= cnt_d;
        end
    end

`ifdef SIMMEM_WRESP_DELAY_TRACKER_STATS_EN
    localparam int CntWidth = IdxWidth + 1;

    logic [CntWidth-1:0] occupancy_q, occupancy_d;
    logic [CntWidth-1:0] max_occ_q, max_occ_d;

    // Occupancy never exceeds NumSlots, so the high-water mark saturates there on its own.
    always_comb begin
        occupancy_d = occupancy_q;
        if (accept && !release_fire) begin
            occupancy_d = occupancy_q + 1'b1;
        end else if (!accept && release_fire) begin
            occupancy_d = occupancy_q - 1'b1;
        end
        max_occ_d = (occupancy_d > max_occ_q) ? occupancy_d : max_occ_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            occupancy_q <= '0;
            max_occ_q   <= '0;
        end else begin
            occupancy_q <= occupancy_d;
            max_occ_q   <= max_occ_d;
        end
    end

    assign occupancy_o     = occupancy_q;
    assign max_occupancy_o = max_occ_q;
`endif

endmodule

// File: tb/tb_simmem_wresp_delay_tracker.sv
// Scoreboard bench for simmem_wresp_delay_tracker: stimulus queues expected (id, cycle) releases,
// a negedge monitor checks every release handshake against them.
module tb_simmem_wresp_delay_tracker;

    localparam int NumSlots   = 16;
    localparam int IdWidth    = 4;
    localparam int DelayWidth = 6;

    typedef struct {
        logic [IdWidth-1:0] id;
        int                 cyc;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rst_ni = 1'b0;
    logic [IdWidth-1:0]    local_id = '0;
    logic [DelayWidth-1:0] delay = '0;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic [IdWidth-1:0]    release_id;
    logic                  release_valid;
    logic                  release_ready = 1'b1;
`ifdef SIMMEM_WRESP_DELAY_TRACKER_STATS_EN
    logic [$clog2(NumSlots):0] occupancy;
    logic [$clog2(NumSlots):0] max_occupancy;
`endif

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    exp_t sb[$];

    simmem_wresp_delay_tracker #(
        .NumSlots  (NumSlots),
        .IdWidth   (IdWidth),
        .DelayWidth(DelayWidth)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .local_id_i     (local_id),
        .delay_i        (delay),
        .in_valid_i     (in_valid),
        .in_ready_o     (in_ready),
        .release_id_o   (release_id),
        .release_valid_o(release_valid),
        .release_ready_i(release_ready)
`ifdef SIMMEM_WRESP_DELAY_TRACKER_STATS_EN
        ,
        .occupancy_o    (occupancy),
        .max_occupancy_o(max_occupancy)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Keeps the scoreboard ordered by expected release cycle.
    function automatic void push_exp(input logic [IdWidth-1:0] id, input int c);
        exp_t e;
        int   pos;
        e.id  = id;
        e.cyc = c;
        pos   = sb.size();
        for (int k = 0; k < sb.size(); k++) begin
            if (sb[k].cyc > c) begin
                pos = k;
                break;
            end
        end
        sb.insert(pos, e);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; the handshake happens on the next edge.
    task automatic do_accept(input logic [IdWidth-1:0] id, input logic [DelayWidth-1:0] d,
                             input bit push);
        check("in_ready_before_accept", in_ready, 1);
        local_id = id;
        delay    = d;
        in_valid = 1'b1;
        if (push) push_exp(id, cyc + 1 + int'(d));
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            step();
            n++;
        end
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: %0d releases outstanding, required 0", sb.size());
            sb.delete();
        end
        repeat (3) step();
    endtask

    always @(negedge clk) begin
        if (rst_ni) begin
            if (release_valid && release_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_release: got id %0d in cycle %0d, required none",
                             release_id, cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("release_id", release_id, e.id);
                    check("release_cycle", cyc, e.cyc);
                end
            end else if (!release_valid) begin
                check("idle_release_id", release_id, 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t;

        #2;
        check("reset_in_ready", in_ready, 1);
        check("reset_release_valid", release_valid, 0);
        check("reset_release_id", release_id, 0);
        step();
        step();
        rst_ni = 1'b1;
        step();

        // Single entry: id 3, delay 10 -> eligible 11 cycles after the accept cycle.
        do_accept(4'd3, 6'd10, 1'b1);
        wait_drain(40);

        // Delay 0: released in the very next cycle.
        do_accept(4'd7, 6'd0, 1'b1);
        wait_drain(10);

        // Back-to-back delay-0 accepts overlap accept and release in the same cycle.
        do_accept(4'd1, 6'd0, 1'b1);
        do_accept(4'd6, 6'd0, 1'b1);
        do_accept(4'd11, 6'd0, 1'b1);
        wait_drain(10);

        // Duplicate IDs in different slots plus the maximum delay.
        do_accept(4'd2, 6'd3, 1'b1);
        do_accept(4'd2, 6'd5, 1'b1);
        do_accept(4'd5, 6'd63, 1'b1);
        wait_drain(100);

        // Preemption: the later, shorter entry in slot 1 leaves before slot 0.
        do_accept(4'd9, 6'd20, 1'b1);
        do_accept(4'd4, 6'd1, 1'b1);
        wait_drain(40);

        // Full under backpressure, then drain in slot order.
        release_ready = 1'b0;
        for (int k = 0; k < NumSlots; k++) do_accept(IdWidth'(k), 6'd2, 1'b0);
        check("full_in_ready", in_ready, 0);
        local_id = 4'd13;
        delay    = 6'd0;
        in_valid = 1'b1;
        repeat (3) step();
        in_valid = 1'b0;
        check("held_release_valid", release_valid, 1);
        check("held_release_id", release_id, 0);
        t = cyc;
        release_ready = 1'b1;
        for (int k = 0; k < NumSlots; k++) push_exp(IdWidth'(k), t + k);
        check("in_ready_in_first_release_cycle", in_ready, 0);
        step();
        check("in_ready_after_first_release", in_ready, 1);
        wait_drain(40);

        // Reset mid-operation discards in-flight entries.
        for (int k = 0; k < 5; k++) do_accept(IdWidth'(8 + k), 6'd30, 1'b1);
        rst_ni = 1'b0;
        #1;
        check("midreset_release_valid", release_valid, 0);
        check("midreset_in_ready", in_ready, 1);
        check("midreset_release_id", release_id, 0);
        sb.delete();
        step();
        rst_ni = 1'b1;
`ifdef SIMMEM_WRESP_DELAY_TRACKER_STATS_EN
        check("midreset_occupancy", occupancy, 0);
        check("midreset_max_occupancy", max_occupancy, 0);
`endif
        repeat (45) step();

        // Three accepts, one lone release, then accept and release together.
        do_accept(4'd1, 6'd40, 1'b1);
        do_accept(4'd2, 6'd3, 1'b1);
        do_accept(4'd3, 6'd1, 1'b1);
`ifdef SIMMEM_WRESP_DELAY_TRACKER_STATS_EN
        check("occupancy_after_three", occupancy, 3);
        check("max_after_three", max_occupancy, 3);
`endif
        step();
        step();
        do_accept(4'd4, 6'd40, 1'b1);
`ifdef SIMMEM_WRESP_DELAY_TRACKER_STATS_EN
        check("occupancy_final", occupancy, 2);
        check("max_occupancy_final", max_occupancy, 3);
`endif
        wait_drain(80);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
